dm_load_responder: RTL and testbench

// - Data-memory responder on the far end of the store-alignment interface: accepts word address,

---
 rtl/dm_pkg.sv | 24 ++
 rtl/dm_load_ext.sv | 51 +++++
 rtl/dm_load_responder.sv | 136 +++++++++++++
 tb/tb_dm_load_responder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// ============================================================================
// dm_pkg
// Load-op codes and responder state encoding shared by the data-memory blocks.
// Revision: 1.0
// ============================================================================
`default_nettype none

package dm_pkg;

  localparam logic [2:0] LOAD_LW  = 3'd0;
  localparam logic [2:0] LOAD_LH  = 3'd1;
  localparam logic [2:0] LOAD_LHU = 3'd2;
  localparam logic [2:0] LOAD_LB  = 3'd3;
  localparam logic [2:0] LOAD_LBU = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dm_load_ext.sv
// ============================================================================
// dm_load_ext
// Selects and extends the byte/half/word addressed by a load; flags misalignment.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dm_load_ext
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  load_op,
  output logic [31:0] rdata,
  output logic        err
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  assign w_half = addr_lo[1] ? word[31:16] : word[15:0];
  assign w_byte = word[8*addr_lo +: 8];

  always_comb begin
    rdata = '0;
    err   = 1'b0;
    case (load_op)
      LOAD_LH, LOAD_LHU: begin
        if (addr_lo[0]) begin
          err = 1'b1;
        end else begin
          rdata = {{16{(load_op == LOAD_LH) & w_half[15]}}, w_half};
        end
      end
      LOAD_LB, LOAD_LBU: begin
        rdata = {{24{(load_op == LOAD_LB) & w_byte[7]}}, w_byte};
      end
      // Codes 5..7 behave as lw.
      default: begin
        if (addr_lo != 2'b00) begin
          err = 1'b1;
        end else begin
          rdata = word;
        end
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dm_load_responder.sv
// ============================================================================
// dm_load_responder
// Data-memory responder: byte-masked writes, fixed-latency extended loads.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dm_load_responder
  import dm_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_byteen,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_load_op,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         c_depth     = 1 << ADDR_W;
  localparam logic [3:0] c_wait_init = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic [31:0]         r_rdata;
  logic                r_err;
  logic [ADDR_W-1:0]   r_idx;
  logic [1:0]          r_addr_lo;
  logic [2:0]          r_op;
  logic [31:0]         r_mem [0:c_depth-1];

  logic                w_accept;
  logic                w_is_write;
  logic [ADDR_W-1:0]   w_req_idx;
  logic [31:0]         w_word;
  logic [31:0]         w_ext_rdata;
  logic                w_ext_err;
  logic                w_unused_addr;

  assign w_accept      = req_valid & r_req_ready;
  assign w_is_write    = |req_byteen;
  assign w_req_idx     = req_addr[ADDR_W+1:2];
  assign w_word        = r_mem[r_idx];
  assign w_unused_addr = ^req_addr[31:ADDR_W+2];

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (w_accept && w_is_write) begin
      for (int i = 0; i < 4; i++) begin
        if (req_byteen[i]) begin
          r_mem[w_req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  dm_load_ext u_ext (
    .word    (w_word),
    .addr_lo (r_addr_lo),
    .load_op (r_op),
    .rdata   (w_ext_rdata),
    .err     (w_ext_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_idx        <= '0;
      r_addr_lo    <= 2'b00;
      r_op         <= LOAD_LW;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept && !w_is_write) begin
            r_idx       <= w_req_idx;
            r_addr_lo   <= req_addr[1:0];
            r_op        <= req_load_op;
            r_req_ready <= 1'b0;
            if (LATENCY == 0) begin
              r_state <= RESP;
            end else begin
              r_cnt   <= c_wait_init;
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          // First RESP cycle captures the result; it then holds until consumed.
          if (!r_resp_valid) begin
            r_resp_valid <= 1'b1;
            r_rdata      <= w_ext_rdata;
            r_err        <= w_ext_err;
          end else if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dm_load_responder.sv
// ============================================================================
// tb_dm_load_responder
// Directed self-checking bench for dm_load_responder (ADDR_W=10, LATENCY=2).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dm_load_responder;
  import dm_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_byteen;
  logic [31:0] req_wdata;
  logic [2:0]  req_load_op;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks   = 0;
  int failures = 0;

  dm_load_responder #(.ADDR_W(10), .LATENCY(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_byteen  (req_byteen),
    .req_wdata   (req_wdata),
    .req_load_op (req_load_op),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wait_req_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
    @(negedge clk);
    req_valid   = 1'b1;
    req_addr    = addr;
    req_byteen  = be;
    req_wdata   = data;
    req_load_op = LOAD_LW;
    wait_req_ready("wr");
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_byteen = 4'b0000;
  endtask

  // Issue a read, start it, and return after the acceptance edge (+1).
  task automatic issue_read(input logic [31:0] addr, input logic [2:0] op);
    @(negedge clk);
    req_valid   = 1'b1;
    req_addr    = addr;
    req_byteen  = 4'b0000;
    req_load_op = op;
    wait_req_ready("rd");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string tag, output int n);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'd3);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [2:0] op,
                         input logic [31:0] exp_d, input logic exp_e, input bit early);
    int n;
    resp_ready = early;
    issue_read(addr, op);
    wait_resp(tag, n);
    check({tag, "_rdata"}, resp_rdata, exp_d);
    check({tag, "_err"}, 32'(resp_err), 32'(exp_e));
    check({tag, "_busy"}, 32'(req_ready), 32'd0);
    if (!early) begin
      @(negedge clk);
      resp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check({tag, "_done"}, {30'd0, resp_valid, req_ready}, 32'd1);
  endtask

  initial begin
    int n;
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_addr    = '0;
    req_byteen  = 4'b0000;
    req_wdata   = '0;
    req_load_op = LOAD_LW;
    resp_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    do_write(32'h10, 4'b1111, 32'h12345678);
    do_read("lw_full", 32'h10, LOAD_LW, 32'h12345678, 1'b0, 1'b0);

    do_write(32'h10, 4'b0100, 32'h00AB0000);
    do_read("lb_neg", 32'h12, LOAD_LB, 32'hFFFFFFAB, 1'b0, 1'b0);
    do_read("lbu", 32'h12, LOAD_LBU, 32'h000000AB, 1'b0, 1'b1);
    do_read("lw_merge", 32'h10, LOAD_LW, 32'h12AB5678, 1'b0, 1'b0);
    do_read("lh_pos", 32'h12, LOAD_LH, 32'h000012AB, 1'b0, 1'b0);

    do_write(32'h10, 4'b1100, 32'h80010000);
    do_read("lh_neg", 32'h12, LOAD_LH, 32'hFFFF8001, 1'b0, 1'b0);
    do_read("lhu", 32'h12, LOAD_LHU, 32'h00008001, 1'b0, 1'b0);
    do_read("lb_b3", 32'h13, LOAD_LB, 32'hFFFFFF80, 1'b0, 1'b0);
    do_read("lw_mis", 32'h11, LOAD_LW, 32'h0, 1'b1, 1'b0);
    do_read("lh_mis", 32'h13, LOAD_LH, 32'h0, 1'b1, 1'b0);
    do_read("lw_after_mis", 32'h10, LOAD_LW, 32'h80015678, 1'b0, 1'b0);
    do_read("op7_as_lw", 32'h10, 3'd7, 32'h80015678, 1'b0, 1'b0);

    // Upper address bits fold onto the same word; distinct word stays separate.
    do_read("addr_wrap", 32'h1010, LOAD_LW, 32'h80015678, 1'b0, 1'b0);
    do_write(32'h20, 4'b0011, 32'hFFFFBEEF);
    do_read("lhu_w2", 32'h20, LOAD_LHU, 32'h0000BEEF, 1'b0, 1'b0);

    // Backpressure: response held for 5 cycles, then released.
    resp_ready = 1'b0;
    issue_read(32'h10, LOAD_LW);
    wait_resp("hold", n);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d", i), {resp_valid, req_ready, 30'd0}, {1'b1, 1'b0, 30'd0});
      check($sformatf("hold%0d_rdata", i), resp_rdata, 32'h80015678);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("hold_release", {30'd0, resp_valid, req_ready}, 32'd1);

    // Reset during WAIT aborts the load.
    issue_read(32'h10, LOAD_LW);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid) n++;
    end
    check("abort_no_resp", 32'(n), 32'd0);
    do_read("post_reset", 32'h10, LOAD_LW, 32'h80015678, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
